// File: rtl/seg_pkg.sv
// Shared definitions for the seg_scan display stage.
//   NUM_DIGITS           : number of scanned digits (fixed at 6)
//   bcd_t / seg_t        : 4-bit BCD digit and 7-bit segment vector types
//   SEG_0..SEG_9         : segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   SEG_DASH / SEG_BLANK : invalid-code marker (g only) and all-off pattern
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_if.sv
// Digit/segment bundle between the countdown timer, seg_scan and the display.
//   x5..x0   : BCD digits, x5 = hours tens ... x0 = seconds ones
//   blank_lz : 1 = blank the hours-tens digit when it is zero
//   seg      : segments {g,f,e,d,c,b,a}, active-high
//   dp       : separator / decimal point, active-high
//   dig_en   : one-hot digit enable, bit k drives digit k
// Modports: master = timer/bench side (drives digits), slave = seg_scan.
interface seg_scan_if;
  import seg_pkg::*;

  bcd_t                  x5, x4, x3, x2, x1, x0;
  logic                  blank_lz;
  seg_t                  seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] dig_en;

  modport master (
    output x5, x4, x3, x2, x1, x0, blank_lz,
    input  seg, dp, dig_en
  );

  modport slave (
    input  x5, x4, x3, x2, x1, x0, blank_lz,
    output seg, dp, dig_en
  );

endinterface

// File: rtl/bcd7seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i : 4-bit BCD code
//   seg_o : segments {g,f,e,d,c,b,a}, active-high; codes 10-15 show a dash
module bcd7seg
  import seg_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  // NOTE: every path through an always_comb must assign each output (here via
  // the default arm), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 6-digit 7-segment scanner for the HH:MM:SS countdown timer.
//   clk : system clock, all registers update on its rising edge
//   set : synchronous active-high reset
//   bus : seg_scan_if.slave (digits and blank_lz in; seg, dp, dig_en out)
// Parameter CLK_DIV (>= 1): clk cycles each digit stays selected.
// Scan order is digit 5 (hours tens) down to digit 0; the digits are captured
// into a snapshot at the end of each frame so a frame never mixes two times.
// Macro SEG_SCAN_COLON_BLINK_EN: when defined, the separators (digits 4 and 2)
// light only while the snapshot seconds-ones digit is even; when undefined
// they are lit steadily.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        set,
  seg_scan_if.slave   bus
);

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]      IDX_FIRST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [2:0]            idx_q, idx_d;
  bcd_t                  snap_q [NUM_DIGITS];
  bcd_t                  snap_d [NUM_DIGITS];
  bcd_t                  x_in   [NUM_DIGITS];
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

  logic div_last;
  logic frame_end;
  logic lz_blank;
  logic is_sep;
  bcd_t cur_digit;
  seg_t cur_seg;

  always_comb begin
    x_in[0] = bus.x0;
    x_in[1] = bus.x1;
    x_in[2] = bus.x2;
    x_in[3] = bus.x3;
    x_in[4] = bus.x4;
    x_in[5] = bus.x5;
  end

  assign div_last  = (div_q == DIV_MAX);
  // Last cycle of digit 0 closes the frame; the next frame starts from fresh digits.
  assign frame_end = div_last && (idx_q == 3'd0);

  assign cur_digit = snap_q[idx_q];

  bcd7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  // blank_lz is applied live, but the zero test uses the snapshot so the
  // blanking decision matches the digit actually being shown.
  assign lz_blank = bus.blank_lz && (idx_q == IDX_FIRST) &&
                    (snap_q[NUM_DIGITS-1] == 4'd0);
  // Separators follow HH (digit 4) and MM (digit 2).
  assign is_sep   = (idx_q == 3'd4) || (idx_q == 3'd2);

  always_comb begin
    div_d  = div_last ? '0 : div_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (div_last) begin
      idx_d = (idx_q == 3'd0) ? IDX_FIRST : idx_q - 3'd1;
    end
    if (frame_end) begin
      snap_d = x_in;
    end
  end

  // Outputs are decoded from the current index, so they trail idx by one cycle.
  always_comb begin
    dig_en_d = NUM_DIGITS'(1) << idx_q;
    seg_d    = lz_blank ? SEG_BLANK : cur_seg;
    // dp stays 0 in a blanked slot automatically: blanking only happens on
    // digit 5, which is never a separator position.
`ifdef SEG_SCAN_COLON_BLINK_EN
    dp_d     = is_sep && !snap_q[0][0];
`else
    dp_d     = is_sep;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (set) begin
      div_q    <= '0;
      idx_q    <= IDX_FIRST;
      snap_q   <= x_in;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b0;
      dig_en_q <= '0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.dig_en = dig_en_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (CLK_DIV = 4). The stimulus process pushes the
// hand-computed outputs expected after each clock edge; a monitor pops and
// compares on every falling edge while expectations are queued.
module tb_seg_scan;
  import seg_pkg::*;

  localparam int CLK_DIV = 4;

  typedef struct packed {
    seg_t                  seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] dig_en;
  } exp_t;

  logic clk = 1'b0;
  logic set;

  seg_scan_if bus ();

  seg_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .set (set),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t  exp_q  [$];
  string name_q [$];
  int    tests = 0;
  int    fails = 0;
  bcd_t  cur_snap0;

  task automatic check(input string name, input logic ok);
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL %s: got seg=%b dp=%b dig_en=%b (snap x0=%0d)",
               name, bus.seg, bus.dp, bus.dig_en, cur_snap0);
    end
  endtask

  // Monitor: compare away from the active edge.
  exp_t  m_exp;
  string m_name;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      check(m_name,
            {bus.seg, bus.dp, bus.dig_en} === {m_exp.seg, m_exp.dp, m_exp.dig_en});
    end
  end

  // Separator dp for the snapshot seconds-ones digit of the frame being shown.
  function automatic logic sep_dp(input logic sep, input bcd_t snap0);
`ifdef SEG_SCAN_COLON_BLINK_EN
    return sep && !snap0[0];
`else
    return sep;
`endif
  endfunction

  // One clock edge with the outputs expected right after it.
  task automatic cyc(input string name, input seg_t s, input logic d,
                     input logic [NUM_DIGITS-1:0] en);
    exp_t e;
    e.seg    = s;
    e.dp     = d;
    e.dig_en = en;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // n edges of digit slot k showing segment pattern s (or blanked).
  task automatic slot(input string name, input int k, input seg_t s,
                      input logic blank, input int n);
    logic sep;
    sep = (k == 4) || (k == 2);
    for (int i = 0; i < n; i++) begin
      cyc(name, blank ? SEG_BLANK : s,
          blank ? 1'b0 : sep_dp(sep, cur_snap0),
          NUM_DIGITS'(1) << k);
    end
  endtask

  task automatic set_digits(input bcd_t d5, input bcd_t d4, input bcd_t d3,
                            input bcd_t d2, input bcd_t d1, input bcd_t d0);
    bus.x5 = d5; bus.x4 = d4; bus.x3 = d3;
    bus.x2 = d2; bus.x1 = d1; bus.x0 = d0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set          = 1'b1;
    bus.blank_lz = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    cur_snap0    = 4'd6;
    #1;

    // Reset hold: all outputs 0 for three edges.
    for (int i = 0; i < 3; i++) cyc("reset_hold", SEG_BLANK, 1'b0, '0);
    check("reset_seg",    bus.seg === SEG_BLANK);
    check("reset_dp",     bus.dp === 1'b0);
    check("reset_dig_en", bus.dig_en === '0);
    set = 1'b0;

    // Frame A: 12:34:56 in scan order, first slot lasts CLK_DIV cycles.
    slot("A_d5", 5, SEG_1, 1'b0, CLK_DIV);
    slot("A_d4", 4, SEG_2, 1'b0, CLK_DIV);
    slot("A_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("A_d2", 2, SEG_4, 1'b0, CLK_DIV);
    slot("A_d1", 1, SEG_5, 1'b0, CLK_DIV);
    slot("A_d0", 0, SEG_6, 1'b0, CLK_DIV);

    // Frame B: x0 changes 6->5 while idx = 3; this frame must still show 6.
    slot("B_d5", 5, SEG_1, 1'b0, CLK_DIV);
    slot("B_d4", 4, SEG_2, 1'b0, CLK_DIV);
    bus.x0 = 4'd5;
    slot("B_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("B_d2", 2, SEG_4, 1'b0, CLK_DIV);
    slot("B_d1", 1, SEG_5, 1'b0, CLK_DIV);
    slot("B_d0_old", 0, SEG_6, 1'b0, CLK_DIV);

    // Frame C: new x0 visible. x5 -> 0 and blank_lz -> 1 now; the snapshot
    // still holds x5 = 1, so no blanking in this frame.
    cur_snap0    = 4'd5;
    bus.x5       = 4'd0;
    bus.blank_lz = 1'b1;
    slot("C_d5_noblank", 5, SEG_1, 1'b0, CLK_DIV);
    slot("C_d4", 4, SEG_2, 1'b0, CLK_DIV);
    slot("C_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("C_d2", 2, SEG_4, 1'b0, CLK_DIV);
    slot("C_d1", 1, SEG_5, 1'b0, CLK_DIV);
    slot("C_d0_new", 0, SEG_5, 1'b0, CLK_DIV);

    // Frame D: leading zero blanked; queue x2 = C and x0 = 4 for the next frame.
    set_digits(4'd0, 4'd2, 4'd3, 4'hC, 4'd5, 4'd4);
    slot("D_d5_blank", 5, SEG_0, 1'b1, CLK_DIV);
    slot("D_d4", 4, SEG_2, 1'b0, CLK_DIV);
    slot("D_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("D_d2", 2, SEG_4, 1'b0, CLK_DIV);
    slot("D_d1", 1, SEG_5, 1'b0, CLK_DIV);
    slot("D_d0", 0, SEG_5, 1'b0, CLK_DIV);

    // Frame E: blank_lz off shows the zero; x2 = C shows a dash; x0 = 4 (even).
    bus.blank_lz = 1'b0;
    cur_snap0    = 4'd4;
    bus.x0       = 4'd3;
    slot("E_d5_zero", 5, SEG_0, 1'b0, CLK_DIV);
    slot("E_d4_sep_even", 4, SEG_2, 1'b0, CLK_DIV);
    slot("E_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("E_d2_dash", 2, SEG_DASH, 1'b0, CLK_DIV);
    slot("E_d1", 1, SEG_5, 1'b0, CLK_DIV);
    slot("E_d0", 0, SEG_4, 1'b0, CLK_DIV);

    // Frame F: x0 = 3 (odd); abort with set while idx = 2.
    cur_snap0 = 4'd3;
    slot("F_d5", 5, SEG_0, 1'b0, CLK_DIV);
    slot("F_d4_sep_odd", 4, SEG_2, 1'b0, CLK_DIV);
    slot("F_d3", 3, SEG_3, 1'b0, CLK_DIV);
    slot("F_d2_dash", 2, SEG_DASH, 1'b0, 2);
    set = 1'b1;
    cyc("midframe_reset", SEG_BLANK, 1'b0, '0);
    check("midframe_seg",    bus.seg === SEG_BLANK);
    check("midframe_dp",     bus.dp === 1'b0);
    check("midframe_dig_en", bus.dig_en === '0);
    set = 1'b0;

    // Frame G: scan restarts at digit 5 for a full slot.
    slot("G_restart_d5", 5, SEG_0, 1'b0, CLK_DIV);
    slot("G_d4", 4, SEG_2, 1'b0, CLK_DIV);
    check("G_d4_dig_en", bus.dig_en === 6'b010000);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Display stage directly downstream of the six-digit BCD countdown timer (HH:MM:SS) in the nightlight design.
- Consumes the timer's six 4-bit digits and drives a time-multiplexed 6-digit common-segment 7-segment display, one digit per scan slot.
- Snapshots the digits once per frame so a frame never mixes old and new digits, and shows separators between hours, minutes and seconds.

Parameters:
- CLK_DIV, 4: clk cycles each digit stays selected; legal range >= 1.
- NUM_DIGITS, 6: digit count; fixed at 6; comes from the package.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- set  in  1  reset; synchronous, active-high.
- x5..x0  in  4 each  BCD digits from the timer: x5 = hours tens … x0 = seconds ones.
- blank_lz  in  1  1 = blank the hours-tens digit when it is 0.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  out  1  decimal point / separator, active-high.
- dig_en  out  6  one-hot digit enable, active-high; bit k drives digit k.

Behaviour:
- Reset (set=1 at a clock edge):
  - div <= 0, idx <= 5.
  - snapshot <= {x5..x0}.
  - seg, dp, dig_en <= 0.
- Divider counter div counts 0..CLK_DIV-1. When div == CLK_DIV-1:
  - div wraps to 0.
  - idx steps 5 -> 4 -> 3 -> 2 -> 1 -> 0 -> 5.
- Snapshot loads from {x5..x0} only when div == CLK_DIV-1 and idx == 0 (end of frame), or during reset. Mid-frame input changes are ignored.
- Output registers update every cycle while set = 0. They are decoded from the current idx and snapshot, so outputs have 1 cycle of latency relative to idx.
  - dig_en = 1 << idx.
  - seg = decode(snapshot[idx]).
- Frame length = 6*CLK_DIV cycles. After set falls, dig_en = 6'b100000 from cycle 1 through cycle CLK_DIV.
- Decode:
  - 0–9 use the standard patterns from the package.
  - Codes 10–15 (invalid BCD) show DASH (g only, 7'b1000000).
- Leading-zero blank: when idx == 5, blank_lz = 1 and snapshot[5] == 0, seg = 0 and dp = 0. dig_en still asserts, so scan timing is unchanged.
- dp: asserted on idx 4 and idx 2 (separators after HH and MM), 0 on all other digits. Subject to the Optional Feature.
- set asserted mid-frame aborts the frame immediately. Outputs go to 0 on the next edge and the scan restarts at idx 5.
- CLK_DIV = 1: idx advances every cycle and the snapshot loads every 6 cycles.

Optional Feature:
- Macro SEG_SCAN_COLON_BLINK_EN.
  - Defined: dp on idx 4/2 is additionally gated by ~snapshot[0][0], so separators light only when the seconds-ones digit is even. They blink at half the timer tick rate.
  - Undefined: separators are lit steadily on idx 4 and idx 2.
- Reset values and leading-zero blanking are identical either way.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS = 6.
  - SEG_0..SEG_9, SEG_DASH = 7'b1000000, SEG_BLANK = 7'b0000000.
  - A typedef for the 4-bit BCD digit and one for the 7-bit segment vector.
- Sub-module bcd7seg is purely combinational: 4-bit in -> 7-bit segment out, with invalid codes mapped to DASH. It is instantiated once in seg_scan.
- seg_scan holds the divider, index counter, snapshot registers and output registers.

Test Plan:
- Reset hold: set = 1 for 3 cycles, then release, with CLK_DIV = 4 -> seg, dp and dig_en are 0 during reset; dig_en = 6'b100000 on cycles 1–4 after release, then 6'b010000 on cycles 5–8.
- Digit values: inputs 1,2:3,4:5,6, blank_lz = 0 -> over one frame seg = SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6 in order; dp = 1 only while dig_en[4] and dig_en[2] are set (macro undefined).
- Snapshot coherence: change x0 from 6 to 5 while idx = 3 -> digit 0 still shows SEG_6 in that frame and SEG_5 in the next frame.
- Leading zero: x5 = 0, blank_lz = 1 -> during the dig_en[5] slot seg = 0 and dp = 0. With blank_lz = 0 the same slot shows SEG_0.
- Invalid BCD and mid-frame reset: x2 = 4'hC -> SEG_DASH in the x2 slot; then assert set while idx = 2 -> all outputs 0 at the next edge, and the scan restarts at dig_en = 6'b100000.
- Macro defined: x0 = 4 then 3 across two frames -> separator dp is 1 in the first frame and 0 in the second.
